linkspeed_rx: RTL and testbench

Responder half of MBTRAIN.LINKSPEED, the partner to the local linkspeed requester. It consumes sideband requests produced by the remote die's requester and returns the matching responses. It runs the RX-side point test and reports to the mbtrain controller which exit the remote side requested. It also applies a one-deep pending buffer, so a request that arrives while a response is still in flight is not lost.

---
 rtl/linkspeed_rx_if.sv | 26 ++
 rtl/linkspeed_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_linkspeed_rx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/linkspeed_rx_if.sv
// Sideband request/response bundle between the remote-request decoder and the LINKSPEED responder.
interface linkspeed_rx_if #(
  parameter int MSG_W = 4
);
  logic [MSG_W-1:0] i_sideband_message;
  logic             i_sideband_valid;
  logic             i_busy_negedge_detected;
  logic [MSG_W-1:0] o_sideband_message;
  logic             o_valid_rx;

  modport master (
    output i_sideband_message,
    output i_sideband_valid,
    output i_busy_negedge_detected,
    input  o_sideband_message,
    input  o_valid_rx
  );

  modport slave (
    input  i_sideband_message,
    input  i_sideband_valid,
    input  i_busy_negedge_detected,
    output o_sideband_message,
    output o_valid_rx
  );
endinterface

// File: rtl/linkspeed_rx.sv
// MBTRAIN.LINKSPEED responder: answers remote sideband requests, runs the RX point test,
// and reports the requested exit; a one-deep buffer holds a request while a response is in flight.
module linkspeed_rx #(
  parameter int MSG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_en,
  linkspeed_rx_if.slave  sb,
  input  logic           i_point_test_ack,
  output logic           o_point_test_en,
  output logic           o_test_ack,
  output logic [2:0]     o_exit_code,
  output logic           o_error_seen,
  output logic           o_unexpected_msg
);

  localparam logic [MSG_W-1:0] START_REQ          = MSG_W'(1);
  localparam logic [MSG_W-1:0] START_RESP         = MSG_W'(2);
  localparam logic [MSG_W-1:0] ERROR_REQ          = MSG_W'(3);
  localparam logic [MSG_W-1:0] ERROR_RESP         = MSG_W'(4);
  localparam logic [MSG_W-1:0] REPAIR_REQ         = MSG_W'(5);
  localparam logic [MSG_W-1:0] REPAIR_RESP        = MSG_W'(6);
  localparam logic [MSG_W-1:0] SPEED_DEGRADE_REQ  = MSG_W'(7);
  localparam logic [MSG_W-1:0] SPEED_DEGRADE_RESP = MSG_W'(8);
  localparam logic [MSG_W-1:0] DONE_REQ           = MSG_W'(9);
  localparam logic [MSG_W-1:0] DONE_RESP          = MSG_W'(10);
  localparam logic [MSG_W-1:0] PHYRETRAIN_REQ     = MSG_W'(11);
  localparam logic [MSG_W-1:0] PHYRETRAIN_RESP    = MSG_W'(12);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_RX_TEST,
    S_WAIT_REQ,
    S_FINISHED
  } state_t;

  typedef struct packed {
    logic             ok;
    logic [MSG_W-1:0] resp;
    logic [2:0]       exit_code;
    logic             finish;
    logic             err;
  } svc_t;

  // Outcome of servicing an exit-phase request; ok=0 means illegal given err_seen.
  function automatic svc_t decode_req(input logic [MSG_W-1:0] code, input logic err_seen);
    svc_t s;
    s = '0;
    case (code)
      DONE_REQ:       begin s.ok = 1'b1; s.resp = DONE_RESP;       s.exit_code = 3'd1; s.finish = 1'b1; end
      PHYRETRAIN_REQ: begin s.ok = 1'b1; s.resp = PHYRETRAIN_RESP; s.exit_code = 3'd2; s.finish = 1'b1; end
      ERROR_REQ:      begin s.ok = 1'b1; s.resp = ERROR_RESP;      s.err = 1'b1; end
      REPAIR_REQ: if (err_seen) begin
        s.ok = 1'b1; s.resp = REPAIR_RESP; s.exit_code = 3'd3; s.finish = 1'b1;
      end
      SPEED_DEGRADE_REQ: if (err_seen) begin
        s.ok = 1'b1; s.resp = SPEED_DEGRADE_RESP; s.exit_code = 3'd4; s.finish = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic             valid_q, valid_d;
  logic             pt_en_q, pt_en_d;
  logic             ack_q, ack_d;
  logic [2:0]       exit_q, exit_d;
  logic             err_q, err_d;
  logic             unexp_q, unexp_d;
  logic             buf_valid_q, buf_valid_d;
  logic [MSG_W-1:0] buf_msg_q, buf_msg_d;

  logic             req, busy, svc_buf, issue, store, clear_all;
  logic [MSG_W-1:0] code;
  svc_t             dn, dn_any, iss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      msg_q       <= '0;
      valid_q     <= 1'b0;
      pt_en_q     <= 1'b0;
      ack_q       <= 1'b0;
      exit_q      <= 3'd0;
      err_q       <= 1'b0;
      unexp_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_msg_q   <= '0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      valid_q     <= valid_d;
      pt_en_q     <= pt_en_d;
      ack_q       <= ack_d;
      exit_q      <= exit_d;
      err_q       <= err_d;
      unexp_q     <= unexp_d;
      buf_valid_q <= buf_valid_d;
      buf_msg_q   <= buf_msg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    valid_d     = valid_q;
    pt_en_d     = pt_en_q;
    ack_d       = ack_q;
    exit_d      = exit_q;
    err_d       = err_q;
    unexp_d     = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_msg_d   = buf_msg_q;

    req       = sb.i_sideband_valid;
    code      = sb.i_sideband_message;
    busy      = sb.i_busy_negedge_detected;
    dn        = decode_req(code, err_q);
    dn_any    = decode_req(code, 1'b1);
    svc_buf   = 1'b0;
    issue     = 1'b0;
    store     = 1'b0;
    iss       = '0;
    clear_all = (state_q == S_IDLE) || !i_en;

    if (busy) valid_d = 1'b0;

    case (state_q)
      S_WAIT_START: if (req) begin
        if (code == START_REQ) begin
          msg_d   = START_RESP;
          valid_d = 1'b1;
          pt_en_d = 1'b1;
          state_d = S_RX_TEST;
        end else begin
          unexp_d = 1'b1;
        end
      end
      S_RX_TEST: begin
        if (i_point_test_ack) begin
          pt_en_d = 1'b0;
          state_d = S_WAIT_REQ;
        end
        // Exit-phase requests are parked until the point test finishes.
        if (req) begin
          if (dn_any.ok) store = 1'b1;
          else           unexp_d = 1'b1;
        end
      end
      S_WAIT_REQ: begin
        svc_buf = buf_valid_q && !valid_q;
        if (svc_buf) begin
          issue       = 1'b1;
          iss         = decode_req(buf_msg_q, err_q);
          buf_valid_d = 1'b0;
        end
        if (req) begin
          if (!dn.ok) unexp_d = 1'b1;
          else if (!svc_buf && (!valid_q || busy)) begin
            issue = 1'b1;
            iss   = dn;
          end else begin
            store = 1'b1;
          end
        end
      end
      S_FINISHED: begin
        ack_d       = 1'b1;
        buf_valid_d = 1'b0;
      end
      default: ;
    endcase

    // A full buffer only yields to PHYRETRAIN; anything else is dropped and flagged.
    if (store) begin
      if (!buf_valid_q || svc_buf) begin
        buf_valid_d = 1'b1;
        buf_msg_d   = code;
      end else if (code == PHYRETRAIN_REQ) begin
        buf_msg_d = code;
      end else begin
        unexp_d = 1'b1;
      end
    end

    if (issue) begin
      if (!iss.ok) begin
        unexp_d = 1'b1;
      end else begin
        msg_d   = iss.resp;
        valid_d = 1'b1;
        if (iss.err) err_d = 1'b1;
        if (iss.finish) begin
          exit_d      = iss.exit_code;
          state_d     = S_FINISHED;
          buf_valid_d = 1'b0;
        end
      end
    end

    if (clear_all) begin
      state_d     = (state_q == S_IDLE && i_en) ? S_WAIT_START : S_IDLE;
      msg_d       = '0;
      valid_d     = 1'b0;
      pt_en_d     = 1'b0;
      ack_d       = 1'b0;
      exit_d      = 3'd0;
      err_d       = 1'b0;
      unexp_d     = 1'b0;
      buf_valid_d = 1'b0;
      buf_msg_d   = '0;
    end
  end

  assign sb.o_sideband_message = msg_q;
  assign sb.o_valid_rx         = valid_q;
  assign o_point_test_en       = pt_en_q;
  assign o_test_ack            = ack_q;
  assign o_exit_code           = exit_q;
  assign o_error_seen          = err_q;
  assign o_unexpected_msg      = unexp_q;

endmodule

// File: tb/tb_linkspeed_rx.sv
// Directed bench for linkspeed_rx: inputs driven on the falling edge, outputs sampled there too.
module tb_linkspeed_rx;

  localparam int MSG_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_en;
  logic       i_point_test_ack;
  logic       o_point_test_en;
  logic       o_test_ack;
  logic [2:0] o_exit_code;
  logic       o_error_seen;
  logic       o_unexpected_msg;

  int n_checks = 0;
  int n_fail   = 0;

  linkspeed_rx_if #(.MSG_W(MSG_W)) sb ();

  linkspeed_rx #(.MSG_W(MSG_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_en             (i_en),
    .sb               (sb.slave),
    .i_point_test_ack (i_point_test_ack),
    .o_point_test_en  (o_point_test_en),
    .o_test_ack       (o_test_ack),
    .o_exit_code      (o_exit_code),
    .o_error_seen     (o_error_seen),
    .o_unexpected_msg (o_unexpected_msg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic send(input logic [3:0] code);
    sb.i_sideband_message = code;
    sb.i_sideband_valid   = 1'b1;
    @(negedge clk);
    sb.i_sideband_valid   = 1'b0;
    sb.i_sideband_message = 4'd0;
  endtask

  task automatic pulse_busy();
    sb.i_busy_negedge_detected = 1'b1;
    @(negedge clk);
    sb.i_busy_negedge_detected = 1'b0;
  endtask

  task automatic enter_rx_test();
    i_en = 1'b1;
    @(negedge clk);
    send(4'd1);
    pulse_busy();
  endtask

  task automatic go_to_wait_req();
    enter_rx_test();
    i_point_test_ack = 1'b1;
    @(negedge clk);
    i_point_test_ack = 1'b0;
  endtask

  task automatic abort();
    i_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    i_en = 1'b0;
    i_point_test_ack = 1'b0;
    sb.i_sideband_message = 4'd0;
    sb.i_sideband_valid = 1'b0;
    sb.i_busy_negedge_detected = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", sb.o_valid_rx, 0);
    check_eq("rst_msg", sb.o_sideband_message, 0);
    check_eq("rst_pten", o_point_test_en, 0);
    check_eq("rst_exit", o_exit_code, 0);
    check_eq("rst_ack", o_test_ack, 0);
    rst_n = 1'b1;

    // Happy path
    i_en = 1'b1;
    @(negedge clk);
    send(4'd1);
    check_eq("hp_start_valid", sb.o_valid_rx, 1);
    check_eq("hp_start_msg", sb.o_sideband_message, 2);
    check_eq("hp_pten_c1", o_point_test_en, 1);
    pulse_busy();
    check_eq("hp_valid_clr", sb.o_valid_rx, 0);
    check_eq("hp_msg_hold", sb.o_sideband_message, 2);
    check_eq("hp_pten_c2", o_point_test_en, 1);
    repeat (3) @(negedge clk);
    check_eq("hp_pten_c5", o_point_test_en, 1);
    i_point_test_ack = 1'b1;
    @(negedge clk);
    i_point_test_ack = 1'b0;
    check_eq("hp_pten_drop", o_point_test_en, 0);
    send(4'd9);
    check_eq("hp_done_msg", sb.o_sideband_message, 10);
    check_eq("hp_done_valid", sb.o_valid_rx, 1);
    check_eq("hp_exit", o_exit_code, 1);
    check_eq("hp_ack_early", o_test_ack, 0);
    pulse_busy();
    check_eq("hp_ack", o_test_ack, 1);
    send(4'd3);
    check_eq("hp_fin_ignore_unexp", o_unexpected_msg, 0);
    check_eq("hp_fin_ignore_valid", sb.o_valid_rx, 0);
    check_eq("hp_exit_frozen", o_exit_code, 1);
    abort();
    check_eq("hp_idle_ack", o_test_ack, 0);
    check_eq("hp_idle_exit", o_exit_code, 0);

    // Error then repair
    go_to_wait_req();
    send(4'd3);
    check_eq("er_msg", sb.o_sideband_message, 4);
    check_eq("er_err_seen", o_error_seen, 1);
    @(negedge clk);
    check_eq("er_valid_hold", sb.o_valid_rx, 1);
    pulse_busy();
    check_eq("er_valid_clr", sb.o_valid_rx, 0);
    send(4'd5);
    check_eq("er_repair_msg", sb.o_sideband_message, 6);
    check_eq("er_repair_exit", o_exit_code, 3);
    abort();

    // Illegal repair without error
    go_to_wait_req();
    send(4'd5);
    check_eq("ir_unexp", o_unexpected_msg, 1);
    check_eq("ir_no_valid", sb.o_valid_rx, 0);
    check_eq("ir_msg_hold", sb.o_sideband_message, 2);
    @(negedge clk);
    check_eq("ir_unexp_pulse", o_unexpected_msg, 0);
    send(4'd9);
    check_eq("ir_still_waitreq", sb.o_sideband_message, 10);
    abort();

    // Buffered DONE during RX_TEST
    enter_rx_test();
    send(4'd9);
    check_eq("bd_no_resp", sb.o_valid_rx, 0);
    check_eq("bd_no_unexp", o_unexpected_msg, 0);
    i_point_test_ack = 1'b1;
    @(negedge clk);
    i_point_test_ack = 1'b0;
    check_eq("bd_entry_valid", sb.o_valid_rx, 0);
    @(negedge clk);
    check_eq("bd_valid", sb.o_valid_rx, 1);
    check_eq("bd_msg", sb.o_sideband_message, 10);
    check_eq("bd_exit", o_exit_code, 1);
    abort();

    // Buffered ERROR while response in flight, then bypass
    go_to_wait_req();
    send(4'd3);
    send(4'd3);
    check_eq("be_valid_held", sb.o_valid_rx, 1);
    pulse_busy();
    check_eq("be_valid_fell", sb.o_valid_rx, 0);
    @(negedge clk);
    check_eq("be_reissue", sb.o_valid_rx, 1);
    check_eq("be_msg", sb.o_sideband_message, 4);
    sb.i_busy_negedge_detected = 1'b1;
    send(4'd3);
    sb.i_busy_negedge_detected = 1'b0;
    check_eq("bp_valid_stays", sb.o_valid_rx, 1);
    pulse_busy();
    @(negedge clk);
    check_eq("bp_no_buffered", sb.o_valid_rx, 0);
    abort();

    // PHYRETRAIN overwrites a full buffer; other requests are dropped
    enter_rx_test();
    send(4'd3);
    send(4'd9);
    check_eq("pr_drop_unexp", o_unexpected_msg, 1);
    send(4'd11);
    check_eq("pr_over_unexp", o_unexpected_msg, 0);
    i_point_test_ack = 1'b1;
    @(negedge clk);
    i_point_test_ack = 1'b0;
    @(negedge clk);
    check_eq("pr_msg", sb.o_sideband_message, 12);
    check_eq("pr_exit", o_exit_code, 2);
    check_eq("pr_no_err", o_error_seen, 0);
    pulse_busy();
    @(negedge clk);
    check_eq("pr_no_more", sb.o_valid_rx, 0);
    abort();

    // Abort mid RX_TEST
    i_en = 1'b1;
    @(negedge clk);
    send(4'd1);
    check_eq("ab_pten_on", o_point_test_en, 1);
    abort();
    check_eq("ab_pten", o_point_test_en, 0);
    check_eq("ab_valid", sb.o_valid_rx, 0);
    check_eq("ab_msg", sb.o_sideband_message, 0);

    // Asynchronous reset mid-handshake
    go_to_wait_req();
    send(4'd3);
    check_eq("ar_valid_before", sb.o_valid_rx, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_valid_now", sb.o_valid_rx, 0);
    check_eq("ar_err", o_error_seen, 0);
    i_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("ar_buffer_empty", sb.o_valid_rx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
